fft_ctrl: RTL and testbench
===========================

// Module: fft_ctrl
// PURPOSE
//   Sequencer for an in-place iterative radix-2 DIT FFT built around one
//   combinational butterfly. Walks LOG2N stages of N/2 butterflies each.
//   Drives read/write addresses of a dual-port sample RAM (input already in
//   bit-reversed order) and the twiddle-ROM index. Issues one butterfly per
//   cycle and reports busy/done to the host-side loader.
// PARAMETERS
//   N          16                  FFT length, power of two, >= 4
//   LOG2N      $clog2(N)           number of stages
//   ADDR_WIDTH LOG2N               sample RAM address width
//   TW_WIDTH   LOG2N-1             twiddle ROM index width (N/2 entries, W_N^m)
// PORTS
//   clock      in   1           rising-edge clock
//   reset      in   1           synchronous, active-high
//   start      in   1           begin a transform; sampled only in IDLE
//   busy       out  1           high from the first RUN cycle through DONE
//   done       out  1           one-cycle pulse when the last write has completed
//   rd_en      out  1           read both RAM ports this cycle
//   rd_addr_a  out  ADDR_WIDTH  butterfly upper-input address (in1)
//   rd_addr_b  out  ADDR_WIDTH  butterfly lower-input address (in2)
//   tw_idx     out  TW_WIDTH    twiddle ROM index, issued with rd_addr_*
//   wr_en      out  1           write out1/out2 this cycle
//   wr_addr_a  out  ADDR_WIDTH  destination of out1
//   wr_addr_b  out  ADDR_WIDTH  destination of out2
//   stage      out  LOG2N       current stage number, for debug and verification
// BEHAVIOUR
//   - The RAM and the twiddle ROM both have 1-cycle read latency. The butterfly
//     is combinational, so its results are written in the cycle after the read.
//   - FSM states are IDLE, RUN, DRAIN and DONE.
//     IDLE:  start=1 -> RUN with stage=0 and k=0.
//     RUN:   rd_en=1 with addresses taken from (stage, k); k++.
//            When k==N/2-1 -> DRAIN.
//     DRAIN: rd_en=0. The write of the last butterfly of the stage happens here.
//            If stage==LOG2N-1 -> DONE; otherwise stage++, k=0 -> RUN.
//     DONE:  done=1 for one cycle -> IDLE.
//   - Address generation for stage s and butterfly k:
//       half = 1<<s
//       j    = k & (half-1)
//       a    = ((k>>s) << (s+1)) | j
//       b    = a + half
//       tw   = j << (LOG2N-1-s)
//   - wr_en and wr_addr_a/b are rd_en and rd_addr_a/b delayed one cycle by
//     registers. No other path drives them.
//   - The DRAIN bubble is the only RAW-hazard guard between stages. Within a
//     stage all addresses are disjoint.
//   - Timing: cycles per stage = N/2+1. If start is high in cycle 0, done is
//     high in cycle 1 + LOG2N*(N/2+1). For N=16 that is cycle 37.
//   - start is ignored while busy; there is no queueing.
//   - Reset values: state IDLE; stage, k and all addresses 0; rd_en, wr_en,
//     busy and done all 0.
//   - Reset mid-operation: the FSM returns to IDLE at that clock edge. wr_en is
//     low in the following cycle, so no partial write issues after reset. RAM
//     contents are left undefined.
//   - start asserted in the same cycle as reset: reset wins and start is dropped.
//   - done and start in the same cycle: start is ignored, because the FSM is not
//     yet in IDLE. A new transform needs start in a later cycle.
// STRUCTURE
//   - fft_pkg holds the fft_ctrl_state_t enum {IDLE,RUN,DRAIN,DONE} and the
//     bf_addr() function (stage, k -> a, b, tw). It imports complex_pkg for the
//     RE/IM indices used by the datapath top level.
//   - One sub-module, fft_addr_gen: purely combinational (stage, k) -> (a, b, tw),
//     reused by the bench as its reference model.
//   - The FSM, the k/stage counters and the 1-stage write-address delay all live
//     in fft_ctrl.
// TESTING (N=16)
//   1. reset, then start pulse in cycle 0 -> busy rises in cycle 1;
//      stage 0 reads (0,1),(2,3)..(14,15), all with tw=0; done pulse in cycle 37.
//   2. Stage 1, k=3 -> rd_addr_a=5, rd_addr_b=7, tw_idx=4.
//      Stage 2, k=5 -> a=9, b=13, tw_idx=2.
//      Stage 3, k=5 -> a=5, b=13, tw_idx=5.
//   3. Every wr_en/wr_addr pair equals the rd_en/rd_addr pair one cycle earlier.
//      Exactly 32 writes per transform, and the DRAIN cycle writes the last pair
//      of each stage.
//   4. start held high continuously -> exactly one transform per IDLE visit;
//      pulses while busy=1 have no effect.
//   5. reset asserted in cycle 15 (mid stage 1) -> cycle 16 has rd_en=wr_en=0,
//      busy=0, stage=0. A fresh start then completes 37 cycles later.
//   6. End-to-end: load the bit-reversed impulse x[0]=1.0 (1<<14) into the RAM,
//      run with the real butterfly -> all 16 bins read RE=16384 (+/-1 LSB), IM=0.

Source files
------------

// File: rtl/complex_pkg.sv
// Field indices for complex samples packed as {re, im} in the FFT datapath.
package complex_pkg;

    localparam int RE = 1;
    localparam int IM = 0;

endpackage

// File: rtl/fft_pkg.sv
// Shared FFT sequencer types: FSM state encoding and butterfly address mapping.
package fft_pkg;

    import complex_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_ctrl_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tw;
    } bf_addr_t;

    // Butterfly k of stage s pairs a and a+2^s; j is the position inside the group.
    function automatic bf_addr_t bf_addr(input int unsigned s, input int unsigned k,
                                         input int unsigned log2n);
        bf_addr_t    r;
        int unsigned half;
        int unsigned j;
        half = 32'd1 << s;
        j    = k & (half - 32'd1);
        r.a  = ((k >> s) << (s + 32'd1)) | j;
        r.b  = r.a + half;
        r.tw = j << (log2n - 32'd1 - s);
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational (stage, k) -> butterfly read addresses and twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N          = 16,
    parameter int LOG2N      = $clog2(N),
    parameter int ADDR_WIDTH = LOG2N,
    parameter int TW_WIDTH   = LOG2N - 1
) (
    input  logic [LOG2N-1:0]      stage,
    input  logic [LOG2N-2:0]      k,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [ADDR_WIDTH-1:0] b,
    output logic [TW_WIDTH-1:0]   tw
);

    bf_addr_t r;

    always_comb begin
        r  = bf_addr(32'(stage), 32'(k), LOG2N);
        a  = ADDR_WIDTH'(r.a);
        b  = ADDR_WIDTH'(r.b);
        tw = TW_WIDTH'(r.tw);
    end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, one bubble per stage,
// write addresses are the read addresses delayed by one register stage.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N          = 16,
    parameter int LOG2N      = $clog2(N),
    parameter int ADDR_WIDTH = LOG2N,
    parameter int TW_WIDTH   = LOG2N - 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [TW_WIDTH-1:0]   tw_idx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr_a,
    output logic [ADDR_WIDTH-1:0] wr_addr_b,
    output logic [LOG2N-1:0]      stage,
    output fft_ctrl_state_t       fsm_state
);

    // N is a power of two, so the last butterfly index N/2-1 is all ones.
    localparam logic [LOG2N-2:0] K_LAST     = '1;
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);

    fft_ctrl_state_t        state;
    fft_ctrl_state_t        state_next;
    logic [LOG2N-2:0]       k;
    logic [ADDR_WIDTH-1:0]  gen_a;
    logic [ADDR_WIDTH-1:0]  gen_b;
    logic [TW_WIDTH-1:0]    gen_tw;

    fft_addr_gen #(
        .N          (N),
        .LOG2N      (LOG2N),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TW_WIDTH   (TW_WIDTH)
    ) u_addr_gen (
        .stage (stage),
        .k     (k),
        .a     (gen_a),
        .b     (gen_b),
        .tw    (gen_tw)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (k == K_LAST) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = (stage == STAGE_LAST) ? DONE : RUN;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k     <= '0;
            stage <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k     <= '0;
                        stage <= '0;
                    end
                end
                RUN: begin
                    k <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                DRAIN: begin
                    if (stage != STAGE_LAST) stage <= stage + 1'b1;
                end
                DONE: begin
                    stage <= '0;
                end
                default: begin
                    k     <= '0;
                    stage <= '0;
                end
            endcase
        end
    end

    // Addresses are held at zero outside RUN so idle outputs stay quiet.
    assign rd_addr_a = rd_en ? gen_a  : '0;
    assign rd_addr_b = rd_en ? gen_b  : '0;
    assign tw_idx    = rd_en ? gen_tw : '0;
    assign fsm_state = state;

    // The butterfly result is ready one cycle after the read, so the write
    // side is simply the read side delayed by one register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr_a <= '0;
            wr_addr_b <= '0;
        end else begin
            wr_en     <= rd_en;
            wr_addr_a <= rd_addr_a;
            wr_addr_b <= rd_addr_b;
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl (N=16): timing, address order, reset behaviour
// and an end-to-end transform through a behavioural RAM and butterfly.
module tb_fft_ctrl;

    import fft_pkg::*;

    localparam int N         = 16;
    localparam int LOG2N     = 4;
    localparam int AW        = 4;
    localparam int TWW       = 3;
    localparam int STAGE_CYC = N / 2 + 1;
    localparam int DONE_CYC  = 1 + LOG2N * STAGE_CYC;
    localparam int TOL       = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, rd_en, wr_en;
    logic [AW-1:0]   rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [TWW-1:0]  tw_idx;
    logic [LOG2N-1:0] stage;
    fft_ctrl_state_t fsm_state;

    int tests = 0;
    int fails = 0;

    logic [2*AW+TWW-1:0] exp_q[$];

    always #5 clock = ~clock;

    fft_ctrl #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage),
        .fsm_state (fsm_state)
    );

    // ---------------- behavioural RAM, twiddle ROM and butterfly ----------------
    int   mem_re[N], mem_im[N], ld_re[N], ld_im[N];
    int   tw_re[N/2], tw_im[N/2];
    int   d1r, d1i, d2r, d2i, dtw;
    logic load_req = 1'b0;
    logic q_rd_en, q_wr_en;
    logic [AW-1:0] q_ra, q_rb, q_wa, q_wb;
    logic [TWW-1:0] q_tw;

    initial begin
        for (int m = 0; m < N / 2; m++) begin
            tw_re[m] = $rtoi($floor(16384.0 * $cos(2.0 * 3.14159265358979 * m / N) + 0.5));
            tw_im[m] = $rtoi($floor(-16384.0 * $sin(2.0 * 3.14159265358979 * m / N) + 0.5));
        end
    end

    always @(negedge clock) begin
        q_rd_en = rd_en;  q_ra = rd_addr_a;  q_rb = rd_addr_b;  q_tw = tw_idx;
        q_wr_en = wr_en;  q_wa = wr_addr_a;  q_wb = wr_addr_b;
    end

    always @(posedge clock) begin
        int tr, ti;
        if (load_req) begin
            for (int n = 0; n < N; n++) begin
                mem_re[n] = ld_re[n];
                mem_im[n] = ld_im[n];
            end
        end else begin
            if (q_wr_en) begin
                tr = (d2r * tw_re[dtw] - d2i * tw_im[dtw] + 8192) >>> 14;
                ti = (d2r * tw_im[dtw] + d2i * tw_re[dtw] + 8192) >>> 14;
                mem_re[q_wa] = d1r + tr;  mem_im[q_wa] = d1i + ti;
                mem_re[q_wb] = d1r - tr;  mem_im[q_wb] = d1i - ti;
            end
            if (q_rd_en) begin
                d1r = mem_re[q_ra];  d1i = mem_im[q_ra];
                d2r = mem_re[q_rb];  d2i = mem_im[q_rb];
                dtw = int'(q_tw);
            end
        end
    end

    // Expected read order: stage by stage, groups of 2*half, pairs (g*2h+j, +half).
    task automatic build_model();
        int h;
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            h = 1 << s;
            for (int g = 0; g < N / (2 * h); g++)
                for (int j = 0; j < h; j++)
                    exp_q.push_back({AW'(g * 2 * h + j), AW'(g * 2 * h + j + h), TWW'(j * (N / (2 * h)))});
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) if (v & (1 << i)) r |= 1 << (LOG2N - 1 - i);
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clock);
        tests++;
        if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, rd_en, wr_en});
        end
        tests++;
        if ({rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage} !== '0) begin
            fails++; $display("FAIL reset_addr: got %h expected 0", {rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage});
        end
        tests++;
        if (fsm_state !== IDLE) begin
            fails++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_full_transform();
        logic [2*AW+TWW-1:0] e;
        logic          e_rd, pe_rd;
        logic [AW-1:0] pe_a, pe_b;
        int st, pos, writes;
        build_model();
        pe_rd = 1'b0;  pe_a = '0;  pe_b = '0;  writes = 0;
        start = 1'b1;                       // cycle 0
        for (int c = 1; c <= DONE_CYC + 3; c++) begin
            @(negedge clock);
            start = 1'b0;
            st   = (c - 1) / STAGE_CYC;
            pos  = (c - 1) % STAGE_CYC;
            e_rd = (c < DONE_CYC) && (pos < N / 2);
            tests++;
            if (busy !== (c <= DONE_CYC)) begin
                fails++; $display("FAIL busy c%0d: got %b expected %b", c, busy, c <= DONE_CYC);
            end
            tests++;
            if (done !== (c == DONE_CYC)) begin
                fails++; $display("FAIL done c%0d: got %b expected %b", c, done, c == DONE_CYC);
            end
            tests++;
            if (rd_en !== e_rd) begin
                fails++; $display("FAIL rd_en c%0d: got %b expected %b", c, rd_en, e_rd);
            end
            if (c < DONE_CYC) begin
                tests++;
                if (stage !== LOG2N'(st)) begin
                    fails++; $display("FAIL stage c%0d: got %0d expected %0d", c, stage, st);
                end
            end
            tests++;
            if (wr_en !== pe_rd) begin
                fails++; $display("FAIL wr_en c%0d: got %b expected %b", c, wr_en, pe_rd);
            end
            if (pe_rd) begin
                writes++;
                tests++;
                if (wr_addr_a !== pe_a || wr_addr_b !== pe_b) begin
                    fails++; $display("FAIL wr_addr c%0d: got %0d,%0d expected %0d,%0d", c, wr_addr_a, wr_addr_b, pe_a, pe_b);
                end
            end
            if (c < DONE_CYC && pos == N / 2) begin
                tests++;
                if (wr_en !== 1'b1 || wr_addr_a !== AW'(N - (1 << st) - 1) || wr_addr_b !== AW'(N - 1)) begin
                    fails++; $display("FAIL drain_write s%0d: got en=%b %0d,%0d expected en=1 %0d,%0d", st, wr_en, wr_addr_a, wr_addr_b, N - (1 << st) - 1, N - 1);
                end
            end
            if (e_rd) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL rd_order c%0d: got extra read expected none", c);
                    pe_a = '0;  pe_b = '0;
                end else begin
                    e = exp_q.pop_front();
                    if ({rd_addr_a, rd_addr_b, tw_idx} !== e) begin
                        fails++; $display("FAIL rd_addr c%0d: got %0d,%0d,%0d expected %0d,%0d,%0d", c,
                                          rd_addr_a, rd_addr_b, tw_idx, e[2*AW+TWW-1 -: AW], e[AW+TWW-1 -: AW], e[TWW-1:0]);
                    end
                    pe_a = e[2*AW+TWW-1 -: AW];
                    pe_b = e[AW+TWW-1 -: AW];
                end
            end
            if (c == 1 + STAGE_CYC + 3 || c == 1 + 2 * STAGE_CYC + 5 || c == 1 + 3 * STAGE_CYC + 5) begin
                tests++;
                if (c == 1 + STAGE_CYC + 3 && {rd_addr_a, rd_addr_b, tw_idx} !== {4'd5, 4'd7, 3'd4}) begin
                    fails++; $display("FAIL spot_s1k3: got %0d,%0d,%0d expected 5,7,4", rd_addr_a, rd_addr_b, tw_idx);
                end
                if (c == 1 + 2 * STAGE_CYC + 5 && {rd_addr_a, rd_addr_b, tw_idx} !== {4'd9, 4'd13, 3'd2}) begin
                    fails++; $display("FAIL spot_s2k5: got %0d,%0d,%0d expected 9,13,2", rd_addr_a, rd_addr_b, tw_idx);
                end
                if (c == 1 + 3 * STAGE_CYC + 5 && {rd_addr_a, rd_addr_b, tw_idx} !== {4'd5, 4'd13, 3'd5}) begin
                    fails++; $display("FAIL spot_s3k5: got %0d,%0d,%0d expected 5,13,5", rd_addr_a, rd_addr_b, tw_idx);
                end
            end
            pe_rd = e_rd;
        end
        tests++;
        if (writes != N / 2 * LOG2N || exp_q.size() != 0) begin
            fails++; $display("FAIL write_count: got %0d writes, %0d reads left expected %0d, 0", writes, exp_q.size(), N / 2 * LOG2N);
        end
    endtask

    task automatic test_start_held();
        start = 1'b1;                       // cycle 0, held
        for (int c = 1; c <= 2 * DONE_CYC + 6; c++) begin
            @(negedge clock);
            tests++;
            if (done !== (c == DONE_CYC || c == 2 * DONE_CYC + 1)) begin
                fails++; $display("FAIL held_done c%0d: got %b", c, done);
            end
            tests++;
            if (busy !== !(c == DONE_CYC + 1 || c == 2 * DONE_CYC + 2)) begin
                fails++; $display("FAIL held_busy c%0d: got %b", c, busy);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_ignore_busy();
        start = 1'b1;
        for (int c = 1; c <= DONE_CYC + 8; c++) begin
            @(negedge clock);
            tests++;
            if (done !== (c == DONE_CYC)) begin
                fails++; $display("FAIL ign_done c%0d: got %b expected %b", c, done, c == DONE_CYC);
            end
            tests++;
            if (busy !== (c <= DONE_CYC)) begin
                fails++; $display("FAIL ign_busy c%0d: got %b expected %b", c, busy, c <= DONE_CYC);
            end
            if (c < DONE_CYC)       start = 1'($urandom_range(0, 1));
            else if (c == DONE_CYC) start = 1'b1;
            else                    start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        for (int c = 1; c <= 16 + DONE_CYC + 2; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c == 15) begin
                tests++;
                if (busy !== 1'b1 || stage !== 4'd1) begin
                    fails++; $display("FAIL mid_pre: got busy=%b stage=%0d expected 1,1", busy, stage);
                end
                reset = 1'b1;
            end else if (c == 16) begin
                reset = 1'b0;
                tests++;
                if ({rd_en, wr_en, busy, done} !== 4'b0000 || stage !== '0) begin
                    fails++; $display("FAIL mid_after: got %b stage=%0d expected 0000 stage=0", {rd_en, wr_en, busy, done}, stage);
                end
                start = 1'b1;
            end else if (c > 16) begin
                tests++;
                if (done !== (c == 16 + DONE_CYC)) begin
                    fails++; $display("FAIL mid_restart_done c%0d: got %b expected %b", c, done, c == 16 + DONE_CYC);
                end
            end
        end
    endtask

    task automatic test_reset_with_start();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || fsm_state !== IDLE) begin
            fails++; $display("FAIL rst_start: got busy=%b rd_en=%b state=%0d expected 0,0,0", busy, rd_en, fsm_state);
        end
        @(negedge clock);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL rst_start_late: got busy=%b expected 0", busy);
        end
    endtask

    task automatic run_transform(input string name);
        int c;
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 1;
        while (done !== 1'b1 && c < 100) begin
            @(negedge clock);
            c++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++; $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
        @(negedge clock);
    endtask

    task automatic test_end_to_end(input bit impulse);
        int  xr[N], xi[N];
        real er, ei, th;
        string name;
        name = impulse ? "impulse" : "random";
        for (int n = 0; n < N; n++) begin
            xr[n] = impulse ? ((n == 0) ? 16384 : 0) : $urandom_range(0, 400) - 200;
            xi[n] = impulse ? 0 : $urandom_range(0, 400) - 200;
            ld_re[bitrev(n)] = xr[n];
            ld_im[bitrev(n)] = xi[n];
        end
        run_transform(name);
        for (int k = 0; k < N; k++) begin
            er = 0.0;  ei = 0.0;
            for (int n = 0; n < N; n++) begin
                th = 2.0 * 3.14159265358979 * n * k / N;
                er += xr[n] * $cos(th) + xi[n] * $sin(th);
                ei += xi[n] * $cos(th) - xr[n] * $sin(th);
            end
            tests++;
            if ($itor(mem_re[k]) - er > (impulse ? 1.0 : TOL) || er - $itor(mem_re[k]) > (impulse ? 1.0 : TOL) ||
                $itor(mem_im[k]) - ei > (impulse ? 1.0 : TOL) || ei - $itor(mem_im[k]) > (impulse ? 1.0 : TOL)) begin
                fails++; $display("FAIL %s_bin%0d: got %0d,%0d expected %0.1f,%0.1f", name, k, mem_re[k], mem_im[k], er, ei);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_transform();
        test_reset_with_start();
        test_ignore_busy();
        test_start_held();
        test_mid_reset();
        repeat (2) @(negedge clock);
        test_end_to_end(1'b1);
        test_end_to_end(1'b0);
        test_end_to_end(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
